// File: rtl/clk_div_pkg.sv
// Shared defaults, per-channel state layout and period helper for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned DEF_CNT_W  = 32;
    localparam int unsigned DEF_TOGGLE = 500000;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] cnt;
        logic [DEF_CNT_W-1:0] tv;
        logic [DEF_CNT_W-1:0] shadow;
        logic                 pending;
        logic                 phase;
    } chan_state_t;

    // Full output period in input-clock cycles for a given toggle value.
    function automatic longint unsigned period_cycles(input longint unsigned tv);
        return 2 * (tv + 1);
    endfunction

    localparam longint unsigned DEF_PERIOD = period_cycles(DEF_TOGGLE);

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, toggle value with shadow/pending update, divided clock and tick.
// Optional CLK_DIV_PULSE_MODE_EN adds a per-channel one-cycle-per-period output mode.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned DEFAULT_TOGGLE = DEF_TOGGLE
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
`ifdef CLK_DIV_PULSE_MODE_EN
    input  logic             pulse_mode,
`endif
    output logic             pending,
    output logic             divided_clk,
    output logic             tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_tv;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_phase;
    logic             r_tick;
    logic             r_dclk;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_tv_nxt;
    logic [CNT_W-1:0] w_shadow_nxt;
    logic             w_pending_nxt;
    logic             w_phase_nxt;
    logic             w_tick_nxt;
    logic             w_dclk_nxt;
    logic             w_pulse;

`ifdef CLK_DIV_PULSE_MODE_EN
    assign w_pulse = pulse_mode;
`else
    assign w_pulse = 1'b0;
`endif

    // Next-state: clear beats counting; a pending value only lands on a boundary or a clear.
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_tv_nxt      = r_tv;
        w_shadow_nxt  = r_shadow;
        w_pending_nxt = r_pending;
        w_phase_nxt   = r_phase;
        w_tick_nxt    = 1'b0;

        if (sync_clr) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = 1'b0;
            if (r_pending) begin
                w_tv_nxt      = r_shadow;
                w_pending_nxt = 1'b0;
            end
        end else if (en) begin
            if (r_cnt == r_tv) begin
                w_cnt_nxt   = '0;
                w_phase_nxt = ~r_phase;
                w_tick_nxt  = ~r_phase;
                if (r_pending) begin
                    w_tv_nxt      = r_shadow;
                    w_pending_nxt = 1'b0;
                end
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end

        // Loads only arrive while not pending, so they never collide with an apply.
        if (load) begin
            w_shadow_nxt  = load_value;
            w_pending_nxt = 1'b1;
        end

        w_dclk_nxt = w_pulse ? w_tick_nxt : w_phase_nxt;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_cnt     <= '0;
            r_tv      <= CNT_W'(DEFAULT_TOGGLE);
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_phase   <= 1'b0;
            r_tick    <= 1'b0;
            r_dclk    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_tv      <= w_tv_nxt;
            r_shadow  <= w_shadow_nxt;
            r_pending <= w_pending_nxt;
            r_phase   <= w_phase_nxt;
            r_tick    <= w_tick_nxt;
            r_dclk    <= w_dclk_nxt;
        end
    end

    assign pending     = r_pending;
    assign divided_clk = r_dclk;
    assign tick        = r_tick;

endmodule

// File: rtl/clk_divider_multi.sv
// NUM_CH independent clock dividers with runtime-reprogrammable toggle values and global phase clear.
// Optional CLK_DIV_PULSE_MODE_EN adds the pulse_mode input for one-cycle-high outputs.
module clk_divider_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned DEFAULT_TOGGLE = DEF_TOGGLE,
    parameter int unsigned CH_IDX_W       = 2
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                sync_clr,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_IDX_W-1:0] cfg_chan,
    input  logic [CNT_W-1:0]    cfg_value,
`ifdef CLK_DIV_PULSE_MODE_EN
    input  logic [NUM_CH-1:0]   pulse_mode,
`endif
    output logic [NUM_CH-1:0]   divided_clk,
    output logic [NUM_CH-1:0]   tick
);

    localparam int unsigned IDX_SPACE = 1 << CH_IDX_W;

    logic [NUM_CH-1:0]    w_pending;
    logic [NUM_CH-1:0]    w_load;
    logic [IDX_SPACE-1:0] w_pend_map;
    logic                 w_accept;

    // Unpopulated indices read as never-pending, so out-of-range requests are accepted and dropped.
    assign w_pend_map = IDX_SPACE'(w_pending);
    assign cfg_ready  = ~w_pend_map[cfg_chan];
    assign w_accept   = cfg_valid & cfg_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_load[i] = w_accept && (cfg_chan == CH_IDX_W'(i));

        clk_div_chan #(
            .CNT_W          (CNT_W),
            .DEFAULT_TOGGLE (DEFAULT_TOGGLE)
        ) u_chan (
            .clk_in      (clk_in),
            .rst         (rst),
            .en          (ch_en[i]),
            .sync_clr    (sync_clr),
            .load        (w_load[i]),
            .load_value  (cfg_value),
`ifdef CLK_DIV_PULSE_MODE_EN
            .pulse_mode  (pulse_mode[i]),
`endif
            .pending     (w_pending[i]),
            .divided_clk (divided_clk[i]),
            .tick        (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench for clk_divider_multi: hand-derived vector table, directed corner sequences
// and a queue-based scoreboard fed by a behavioural reference of the divider.
module tb_clk_divider_multi;
    import clk_div_pkg::*;

    localparam int unsigned NCH    = 4;
    localparam int unsigned CW     = 16;
    localparam int unsigned IW     = 3;
    localparam int unsigned DEF_TV = 2;
`ifdef CLK_DIV_PULSE_MODE_EN
    localparam bit PULSE_EN = 1'b1;
`else
    localparam bit PULSE_EN = 1'b0;
`endif

    logic           clk_in = 1'b0;
    logic           rst;
    logic [NCH-1:0] ch_en;
    logic           sync_clr;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [IW-1:0]  cfg_chan;
    logic [CW-1:0]  cfg_value;
    logic [NCH-1:0] pm;
    logic [NCH-1:0] divided_clk;
    logic [NCH-1:0] tick;

    always #5 clk_in = ~clk_in;

    clk_divider_multi #(
        .NUM_CH         (NCH),
        .CNT_W          (CW),
        .DEFAULT_TOGGLE (DEF_TV),
        .CH_IDX_W       (IW)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .ch_en       (ch_en),
        .sync_clr    (sync_clr),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_chan    (cfg_chan),
        .cfg_value   (cfg_value),
`ifdef CLK_DIV_PULSE_MODE_EN
        .pulse_mode  (pm),
`endif
        .divided_clk (divided_clk),
        .tick        (tick)
    );

    typedef struct packed {
        logic [NCH-1:0] dclk;
        logic [NCH-1:0] tick;
    } exp_t;

    typedef struct packed {
        logic [NCH-1:0] en;
        logic [NCH-1:0] exp_dclk;
        logic [NCH-1:0] exp_tick;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[12];
    int   n_checks = 0;
    int   n_fail   = 0;

    int unsigned m_cnt [NCH];
    int unsigned m_tv  [NCH];
    int unsigned m_sh  [NCH];
    bit          m_pend[NCH];
    bit          m_ph  [NCH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_ready(input logic [IW-1:0] ch);
        if (int'(ch) >= NCH) return 1'b1;
        return !m_pend[ch];
    endfunction

    // Reference behaviour for one clock edge given the currently driven inputs.
    task automatic model_step(output exp_t e);
        bit acc;
        bit tk;
        acc = cfg_valid && model_ready(cfg_chan);
        for (int i = 0; i < NCH; i++) begin
            tk = 1'b0;
            if (rst) begin
                m_cnt[i] = 0; m_tv[i] = DEF_TV; m_sh[i] = 0; m_pend[i] = 0; m_ph[i] = 0;
            end else begin
                if (sync_clr) begin
                    m_cnt[i] = 0;
                    m_ph[i]  = 0;
                    if (m_pend[i]) begin m_tv[i] = m_sh[i]; m_pend[i] = 0; end
                end else if (ch_en[i]) begin
                    if (m_cnt[i] == m_tv[i]) begin
                        m_cnt[i] = 0;
                        m_ph[i]  = !m_ph[i];
                        tk       = m_ph[i];
                        if (m_pend[i]) begin m_tv[i] = m_sh[i]; m_pend[i] = 0; end
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
                if (acc && int'(cfg_chan) == i) begin
                    m_sh[i]   = int'(cfg_value);
                    m_pend[i] = 1'b1;
                end
            end
            e.tick[i] = tk;
            e.dclk[i] = (PULSE_EN && pm[i]) ? tk : m_ph[i];
        end
    endtask

    // One clock: check ready, push expectation, wait for the edge, pop and compare.
    task automatic step();
        exp_t e;
        exp_t got;
        #1;
        chk("cfg_ready", 32'(cfg_ready), 32'(model_ready(cfg_chan)));
        model_step(e);
        sb_q.push_back(e);
        @(posedge clk_in);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            got = sb_q.pop_front();
            chk("sb_dclk", 32'(divided_clk), 32'(got.dclk));
            chk("sb_tick", 32'(tick), 32'(got.tick));
        end
    endtask

    task automatic cfg_write(input int ch, input int val);
        bit done;
        done      = 1'b0;
        cfg_chan  = IW'(ch);
        cfg_value = CW'(val);
        cfg_valid = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            done = model_ready(cfg_chan);
            step();
        end
        cfg_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL cfg_write_timeout ch=%0d actual=0 required=1", ch);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_cnt;
        vecs[0]  = '{4'hF, 4'h0, 4'h0};
        vecs[1]  = '{4'hF, 4'h0, 4'h0};
        vecs[2]  = '{4'hF, 4'hF, 4'hF};
        vecs[3]  = '{4'hF, 4'hF, 4'h0};
        vecs[4]  = '{4'hF, 4'hF, 4'h0};
        vecs[5]  = '{4'hF, 4'h0, 4'h0};
        vecs[6]  = '{4'hF, 4'h0, 4'h0};
        vecs[7]  = '{4'hF, 4'h0, 4'h0};
        vecs[8]  = '{4'hF, 4'hF, 4'hF};
        vecs[9]  = '{4'hF, 4'hF, 4'h0};
        vecs[10] = '{4'hF, 4'hF, 4'h0};
        vecs[11] = '{4'hF, 4'h0, 4'h0};

        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0; m_tv[i] = DEF_TV; m_sh[i] = 0; m_pend[i] = 0; m_ph[i] = 0;
        end

        rst = 1'b1; ch_en = '0; sync_clr = 1'b0; cfg_valid = 1'b0;
        cfg_chan = '0; cfg_value = '0; pm = '0;
        @(posedge clk_in);
        #1;
        step();
        chk("reset_ready", 32'(cfg_ready), 32'd1);
        chk("reset_dclk", 32'(divided_clk), 32'd0);

        // Default toggle 2: rise at edge 3, fall at edge 6, period 6.
        rst = 1'b0;
        for (int r = 0; r < 12; r++) begin
            ch_en = vecs[r].en;
            step();
            chk($sformatf("vec%0d_dclk", r), 32'(divided_clk), 32'(vecs[r].exp_dclk));
            chk($sformatf("vec%0d_tick", r), 32'(tick), 32'(vecs[r].exp_tick));
        end

        // Reprogram ch1 to 0 while its cnt is 1; second request stalls until the boundary.
        step();
        cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_value = 16'd0;
        step();
        cfg_valid = 1'b0; cfg_chan = 3'd2;
        #1 chk("ch2_ready_while_ch1_pending", 32'(cfg_ready), 32'd1);
        cfg_chan = 3'd1; cfg_valid = 1'b1; cfg_value = 16'd1;
        #1 chk("ch1_stall", 32'(cfg_ready), 32'd0);
        step();
        chk("ch1_rise_old_boundary", 32'(divided_clk[1]), 32'd1);
        chk("ch1_tick_old_boundary", 32'(tick[1]), 32'd1);
        step();
        cfg_valid = 1'b0;
        chk("ch1_fall_period2", 32'(divided_clk[1]), 32'd0);
        step();
        chk("ch1_rise_period2", 32'(divided_clk[1]), 32'd1);
        cfg_write(2, 3);

        // Out-of-phase channels at tv 2..5, then a sync clear.
        cfg_write(0, 2);
        cfg_write(1, 3);
        cfg_write(2, 4);
        cfg_write(3, 5);
        repeat (7) step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        chk("clr_dclk", 32'(divided_clk), 32'd0);
        chk("clr_tick", 32'(tick), 32'd0);
        for (int e = 1; e <= 6; e++) begin
            step();
            for (int c = 0; c < NCH; c++)
                chk($sformatf("clr_rise_ch%0d_e%0d", c, e), 32'(tick[c]), 32'(e == c + 3));
        end

        // Freeze ch0 at cnt 1 for 5 cycles; its first rise moves from edge 3 to edge 8.
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        step();
        ch_en = 4'b1110;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_dclk0", 32'(divided_clk[0]), 32'd0);
            chk("hold_tick0", 32'(tick[0]), 32'd0);
        end
        ch_en = 4'hF;
        step();
        chk("resume_no_rise_e7", 32'(divided_clk[0]), 32'd0);
        step();
        chk("resume_rise_e8", 32'(tick[0]), 32'd1);

        // Out-of-range channel index is accepted and dropped.
        cfg_chan = 3'd5; cfg_value = 16'd0; cfg_valid = 1'b1;
        #1 chk("oor_ready", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;

        // Reset with a pending config.
        cfg_write(3, 9);
        cfg_chan = 3'd3;
        #1 chk("ch3_pending_ready", 32'(cfg_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_dclk", 32'(divided_clk), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        step();
        step();
        step();
        chk("rst_default_tv_rise", 32'(tick), 32'hF);

        // Randomised traffic against the reference.
        for (int k = 0; k < 300; k++) begin
            rst       = ($urandom_range(0, 63) == 0);
            ch_en     = NCH'($urandom);
            sync_clr  = ($urandom_range(0, 31) == 0);
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_chan  = IW'($urandom_range(0, 7));
            cfg_value = CW'($urandom_range(0, 4));
            step();
        end
        rst = 1'b0; sync_clr = 1'b0; cfg_valid = 1'b0; ch_en = 4'hF;

`ifdef CLK_DIV_PULSE_MODE_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        pm = 4'b0101;
        hi_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("pulse_aligned_tick", 32'(divided_clk[0]), 32'(tick[0]));
            if (divided_clk[0]) hi_cnt++;
        end
        chk("pulse_high_count", 32'(hi_cnt), 32'd2);
        pm = '0;
`else
        hi_cnt = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
